test_adc_ctrl: RTL and testbench
================================

# test_adc_ctrl

Sync-triggered ADC burst capture and averaging block for the test ADC path. On a single-cycle `syncro_i` strobe it requests a conversion burst from the external ADC and captures `NUM_SAMPLES` consecutive signed samples while the ADC holds `adc_data_rdy_i` high. It then presents one averaged result on `data_o` with a one-cycle `data_rdy_o` strobe. It sits between the ADC interface and the downstream processing logic.

## Interface
- `DATA_W`, default 12: ADC sample width, two's complement.
- `NUM_SAMPLES`, default 8: samples per burst; a power of two, 2..64.
- `TIMEOUT`, default 64: maximum wait in cycles for `adc_data_rdy_i` after a request.
- `clk_i`, input, 1: the single clock; all logic is on its rising edge.
- `reset_i`, input, 1: reset, asynchronous and active-high.
- `adc_data_req_o`, output, 1: conversion request to the ADC.
- `adc_data_rdy_i`, input, 1: ADC data valid; high for one clock per sample.
- `adc_data_i`, input, `DATA_W`: signed ADC sample, valid while `adc_data_rdy_i` is high.
- `syncro_i`, input, 1: burst start strobe.
- `data_o`, output, `DATA_W`: signed burst result.
- `data_rdy_o`, output, 1: result-valid strobe, one cycle wide.

## Operation
- FSM has three states: IDLE, REQ, CAPTURE.
- IDLE:
  - `syncro_i` high at a clock edge -> REQ. The sample counter, accumulator and timeout counter all clear.
  - `adc_data_rdy_i` high while in IDLE is ignored.
- REQ:
  - `adc_data_req_o` is high.
  - On the first edge with `adc_data_rdy_i` high: capture the sample, set count = 1, go to CAPTURE.
  - `adc_data_req_o` drops at that same edge.
  - If `TIMEOUT` cycles pass without `adc_data_rdy_i` -> IDLE. No result is produced.
- CAPTURE:
  - Each edge with `adc_data_rdy_i` high adds sign-extended `adc_data_i` to the accumulator and increments count.
  - Accumulator width is `DATA_W`+log2(`NUM_SAMPLES`), so it cannot overflow.
- Burst complete: at the edge that captures sample number `NUM_SAMPLES`:
  - `data_o` <= (accumulator + sample) >>> log2(`NUM_SAMPLES`). This is an arithmetic shift, rounding toward minus infinity.
  - `data_rdy_o` <= 1.
  - State -> IDLE.
- Short burst: `adc_data_rdy_i` low in CAPTURE before `NUM_SAMPLES` samples are taken -> IDLE. The partial burst is discarded; `data_o` and `data_rdy_o` are unchanged.
- `syncro_i` during REQ or CAPTURE is ignored; there is no queuing.
- `syncro_i` in the same cycle that a burst completes is also ignored, because the FSM is not yet in IDLE.
- `data_o` holds its value until the next completed burst.

## Timing
- Reset values: `adc_data_req_o` = 0, `data_rdy_o` = 0, `data_o` = 0, state IDLE, all counters 0.
- `reset_i` asserted at any time, including mid-burst, aborts the burst immediately. All outputs go to their reset values asynchronously.
- `syncro_i` sampled high at edge T -> `adc_data_req_o` high from T+1.
- Capture:
  - `adc_data_rdy_i` and `adc_data_i` are sampled on the same edge.
  - The first sample can be taken at T+1 at the earliest.
- Result:
  - `data_rdy_o` is high for exactly one cycle, starting at the edge after the last sample.
  - `data_o` is valid from that edge on.
  - Latency from the last sample is 1 cycle.
- `data_rdy_o` goes low in the following cycle unconditionally.
- Minimum spacing from `data_rdy_o` to the next accepted `syncro_i` is 1 cycle, since the FSM is in IDLE during the `data_rdy_o` cycle.

## Configuration
- Macro `TEST_ADC_CTRL_AVG_EN`.
- Defined: `data_o` is the floor average of the burst, as described in Operation.
- Not defined:
  - The accumulator is not synthesized.
  - `data_o` is the last captured sample of the burst, i.e. sample number `NUM_SAMPLES`.
  - All FSM, handshake, abort and timing behaviour is identical.

## Test plan
- Reset: hold `reset_i` 500 ns, then release -> all outputs 0. `adc_data_rdy_i` pulses in IDLE produce no `data_rdy_o`.
- Nominal burst:
  - Stimulus: `syncro_i` 1-cycle pulse, then 8 rdy cycles with samples 100,100,…,100.
  - Required: `adc_data_req_o` high from the cycle after sync until the first rdy; `data_rdy_o` one pulse 1 cycle after the 8th sample; `data_o` = 100. Without the macro, `data_o` = last sample = 100.
- Sign and rounding:
  - Samples 2047×8 -> 2047.
  - Samples −2048×8 -> −2048.
  - Samples {−1,0,0,0,0,0,0,0} -> −1 (floor).
  - Samples {1..8} -> 4 (36>>>3).
- Short burst and timeout:
  - rdy high for only 5 cycles -> no `data_rdy_o`, `data_o` unchanged.
  - Sync with no rdy for 64 cycles -> `adc_data_req_o` drops at cycle 64, FSM returns to IDLE.
- Back-to-back: 8 sync-triggered bursts of random samples, each sync 10 cycles after rdy falls. A mid-capture sync is ignored -> exactly 8 `data_rdy_o` pulses, each `data_o` matching a reference floor average.
- Mid-burst reset: assert `reset_i` after 4 samples -> outputs 0 immediately. The next sync produces a correct fresh result with no leftover accumulator contribution.

Source files
------------

// File: rtl/test_adc_ctrl.sv
// Sync-triggered ADC burst capture: requests a burst, captures NUM_SAMPLES samples, outputs one result.
// Optional macro TEST_ADC_CTRL_AVG_EN selects floor average; otherwise the last burst sample is output.
module test_adc_ctrl #(
  parameter int DATA_W      = 12,
  parameter int NUM_SAMPLES = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              adc_data_req_o,
  input  logic              adc_data_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              syncro_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o
);

  localparam int SHIFT = $clog2(NUM_SAMPLES);
  localparam int CNT_W = SHIFT + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   count, next_count;
  logic [TMO_W-1:0]   tmo, next_tmo;
  logic               next_req, next_rdy;
  logic [DATA_W-1:0]  next_data;

`ifdef TEST_ADC_CTRL_AVG_EN
  localparam int ACC_W = DATA_W + SHIFT;
  logic [ACC_W-1:0] acc, next_acc;
  logic [ACC_W-1:0] sample_ext;
  logic [ACC_W-1:0] sum;

  // Sign-extend the incoming sample to accumulator width and form the running total.
  always_comb begin
    sample_ext = {{SHIFT{adc_data_i[DATA_W-1]}}, adc_data_i};
    sum        = acc + sample_ext;
  end
`endif

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    next_state = state;
    next_count = count;
    next_tmo   = tmo;
    next_req   = 1'b0;
    next_rdy   = 1'b0;
    next_data  = data_o;
`ifdef TEST_ADC_CTRL_AVG_EN
    next_acc   = acc;
`endif
    case (state)
      IDLE: begin
        if (syncro_i) begin
          next_state = REQ;
          next_count = {CNT_W{1'b0}};
          next_tmo   = {TMO_W{1'b0}};
          next_req   = 1'b1;
`ifdef TEST_ADC_CTRL_AVG_EN
          next_acc   = {ACC_W{1'b0}};
`endif
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (adc_data_rdy_i) begin
          next_state = CAPTURE;
          next_count = CNT_W'(1);
`ifdef TEST_ADC_CTRL_AVG_EN
          next_acc   = sample_ext;
`endif
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          // No answer from the ADC in time: abandon the request silently.
          next_state = IDLE;
        end else begin
          next_tmo = tmo + TMO_W'(1);
          next_req = 1'b1;
        end
      end
      CAPTURE: begin
        if (adc_data_rdy_i) begin
          next_count = count + CNT_W'(1);
          if (count == CNT_W'(NUM_SAMPLES - 1)) begin
            next_state = IDLE;
            next_rdy   = 1'b1;
`ifdef TEST_ADC_CTRL_AVG_EN
            // Arithmetic shift via slice: floor of the average always fits DATA_W.
            next_data  = sum[ACC_W-1:SHIFT];
`else
            next_data  = adc_data_i;
`endif
          end else begin
            next_state = CAPTURE;
`ifdef TEST_ADC_CTRL_AVG_EN
            next_acc   = sum;
`endif
          end
        end else begin
          // Short burst: drop the partial data, keep the previous result.
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      count          <= {CNT_W{1'b0}};
      tmo            <= {TMO_W{1'b0}};
      adc_data_req_o <= 1'b0;
      data_rdy_o     <= 1'b0;
      data_o         <= {DATA_W{1'b0}};
`ifdef TEST_ADC_CTRL_AVG_EN
      acc            <= {ACC_W{1'b0}};
`endif
    end else begin
      state          <= next_state;
      count          <= next_count;
      tmo            <= next_tmo;
      adc_data_req_o <= next_req;
      data_rdy_o     <= next_rdy;
      data_o         <= next_data;
`ifdef TEST_ADC_CTRL_AVG_EN
      acc            <= next_acc;
`endif
    end
  end

endmodule

// File: tb/tb_test_adc_ctrl.sv
// Self-checking bench for test_adc_ctrl: directed steps plus a result scoreboard.
// Expected results follow TEST_ADC_CTRL_AVG_EN (floor average) or last-sample mode.
module tb_test_adc_ctrl;
  localparam int DATA_W = 12;
  localparam int NS     = 8;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req;
  logic              rdy = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              sync = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_rdy;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulses = 0;
  int exp_pulses = 0;
  int samp [NS];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_exp = '0;

  test_adc_ctrl #(.DATA_W(DATA_W), .NUM_SAMPLES(NS), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(rst), .adc_data_req_o(req), .adc_data_rdy_i(rdy),
    .adc_data_i(din), .syncro_i(sync), .data_o(dout), .data_rdy_o(dout_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model();
    int sum = 0;
    for (int i = 0; i < NS; i++) sum += samp[i];
`ifdef TEST_ADC_CTRL_AVG_EN
    return DATA_W'(sum >>> 3);
`else
    return DATA_W'(samp[NS-1]);
`endif
  endfunction

  // Scoreboard: every result strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dout_rdy === 1'b1) begin
      n_pulses++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_pulse observed=%0h expected=none", dout);
      end
      if (exp_q.size() > 0) begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (dout === e) else begin
          n_err++;
          $error("FAIL sb_data observed=%0h expected=%0h", dout, e);
        end
      end
    end
  end

  task automatic sync_pulse();
    @(negedge clk) sync = 1'b1;
    @(negedge clk) sync = 1'b0;
    check("req_rise", 32'(req), 32'd1);
  endtask

  // Drive nsamp consecutive samples; sync_at injects a sync alongside sample sync_at.
  task automatic do_burst(input int nsamp, input bit complete, input int sync_at);
    logic [DATA_W-1:0] e;
    if (complete) begin
      e = model();
      exp_q.push_back(e);
      exp_pulses++;
      last_exp = e;
    end
    for (int i = 0; i < nsamp; i++) begin
      rdy = 1'b1;
      din = DATA_W'(samp[i]);
      sync = (i == sync_at);
      @(negedge clk);
      if (i == 0) check("req_drop", 32'(req), 32'd0);
    end
    rdy = 1'b0;
    sync = 1'b0;
    if (complete) begin
      check("rdy_latency", 32'(dout_rdy), 32'd1);
      check("data", 32'(dout), 32'(e));
      @(negedge clk);
      check("rdy_one_cycle", 32'(dout_rdy), 32'd0);
      check("req_idle", 32'(req), 32'd0);
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NS; i++) samp[i] = v;
  endtask

  initial begin
    #500;
    check("rst_req", 32'(req), 32'd0);
    check("rst_rdy", 32'(dout_rdy), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) rdy = 1'b1; din = 12'd123;
      @(negedge clk) rdy = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("idle_rdy_ignored", 32'(n_pulses), 32'd0);
    check("idle_data", 32'(dout), 32'd0);

    // Nominal burst with the request held for a couple of idle cycles.
    fill_const(100);
    sync_pulse();
    repeat (2) @(negedge clk);
    check("req_held", 32'(req), 32'd1);
    do_burst(NS, 1'b1, -1);

    // Sign and rounding boundaries.
    fill_const(2047);
    sync_pulse(); do_burst(NS, 1'b1, -1);
    fill_const(-2048);
    sync_pulse(); do_burst(NS, 1'b1, -1);
    fill_const(0); samp[0] = -1;
    sync_pulse(); do_burst(NS, 1'b1, -1);
    for (int i = 0; i < NS; i++) samp[i] = i + 1;
    sync_pulse(); do_burst(NS, 1'b1, -1);

    // Short burst: discarded, output unchanged.
    fill_const(-500);
    sync_pulse(); do_burst(5, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("short_pulses", 32'(n_pulses), 32'(exp_pulses));
    check("short_data", 32'(dout), 32'(last_exp));
    check("short_req", 32'(req), 32'd0);

    // Timeout: request lasts exactly TMO cycles.
    sync_pulse();
    repeat (TMO - 1) @(negedge clk);
    check("tmo_req_last", 32'(req), 32'd1);
    @(negedge clk);
    check("tmo_req_drop", 32'(req), 32'd0);
    @(negedge clk) rdy = 1'b1; din = 12'd77;
    @(negedge clk) rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("tmo_no_result", 32'(n_pulses), 32'(exp_pulses));
    check("tmo_data", 32'(dout), 32'(last_exp));

    // Back-to-back random bursts; burst 2 has a mid-capture sync, burst 5 a sync on completion.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NS; i++) samp[i] = int'($urandom_range(4095)) - 2048;
      sync_pulse();
      do_burst(NS, 1'b1, (b == 2) ? 3 : ((b == 5) ? NS - 1 : -1));
      repeat (9) @(negedge clk);
      check("b2b_no_req", 32'(req), 32'd0);
    end
    check("b2b_pulses", 32'(n_pulses), 32'(exp_pulses));

    // Mid-burst reset, then a fresh burst.
    for (int i = 0; i < NS; i++) samp[i] = 1000;
    sync_pulse(); do_burst(4, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    check("mrst_data", 32'(dout), 32'd0);
    check("mrst_rdy", 32'(dout_rdy), 32'd0);
    check("mrst_req", 32'(req), 32'd0);
    @(negedge clk) rst = 1'b0;
    last_exp = '0;
    for (int i = 0; i < NS; i++) samp[i] = -3 * i;
    sync_pulse(); do_burst(NS, 1'b1, -1);

    repeat (3) @(negedge clk);
    check("final_pulses", 32'(n_pulses), 32'(exp_pulses));
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
